palette_arbiter: RTL and testbench

PALETTE_ARBITER -- requirements
Module: palette_arbiter

---
 rtl/palette_arbiter_if.sv | 58 +++++
 rtl/palette_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_palette_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/palette_arbiter_if.sv
// palette_arbiter_if
//   Bundles the three buses around the palette arbiter:
//   - pixel lookup port : pix_req, pix_addr -> pix_data, pix_valid
//   - host download port: dl_start, dl_slot, dl_valid, dl_byte -> dl_ready, dl_done, dl_err
//   - palette RAM port  : mem_addr, mem_we, mem_wdata -> mem_rdata
//   - optional readback : rb_req, rb_addr -> rb_data, rb_valid (PALETTE_READBACK_EN)
//   Modport slave is the arbiter side; modport master is the side that drives
//   the requests and hosts the RAM.
interface palette_arbiter_if;
   logic        pix_req;
   logic [9:0]  pix_addr;
   logic [23:0] pix_data;
   logic        pix_valid;

   logic        dl_start;
   logic [3:0]  dl_slot;
   logic        dl_valid;
   logic [7:0]  dl_byte;
   logic        dl_ready;
   logic        dl_done;
   logic        dl_err;

   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [23:0] mem_wdata;
   logic [23:0] mem_rdata;

`ifdef PALETTE_READBACK_EN
   logic        rb_req;
   logic [9:0]  rb_addr;
   logic [23:0] rb_data;
   logic        rb_valid;

   modport slave (
      input  pix_req, pix_addr, dl_start, dl_slot, dl_valid, dl_byte, mem_rdata,
             rb_req, rb_addr,
      output pix_data, pix_valid, dl_ready, dl_done, dl_err, mem_addr, mem_we,
             mem_wdata, rb_data, rb_valid
   );
   modport master (
      output pix_req, pix_addr, dl_start, dl_slot, dl_valid, dl_byte, mem_rdata,
             rb_req, rb_addr,
      input  pix_data, pix_valid, dl_ready, dl_done, dl_err, mem_addr, mem_we,
             mem_wdata, rb_data, rb_valid
   );
`else
   modport slave (
      input  pix_req, pix_addr, dl_start, dl_slot, dl_valid, dl_byte, mem_rdata,
      output pix_data, pix_valid, dl_ready, dl_done, dl_err, mem_addr, mem_we,
             mem_wdata
   );
   modport master (
      output pix_req, pix_addr, dl_start, dl_slot, dl_valid, dl_byte, mem_rdata,
      input  pix_data, pix_valid, dl_ready, dl_done, dl_err, mem_addr, mem_we,
             mem_wdata
   );
`endif
endinterface

// File: rtl/palette_arbiter.sv
// palette_arbiter
//   Shares one single-port synchronous palette RAM (15 palettes x 64 entries
//   x 24 bit) between a fixed-latency pixel lookup port and a host download
//   port that streams R,G,B bytes per entry.
//   Ports:
//     clk     - system clock
//     reset_n - asynchronous active-low reset
//     bus     - palette_arbiter_if.slave (pixel, download, RAM, optional readback)
//   Optional feature macro: PALETTE_READBACK_EN adds a host readback port that
//   uses RAM cycles left free by pixel lookups and downloads.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no download active
//   COLLECT | dl_ready=1, gathering R, G, B bytes of the current entry
//   WRITE   | entry complete, waiting for a RAM cycle free of pix_req
//   DONE    | entry 63 written, dl_done high for this one cycle
module palette_arbiter (
   input  logic             clk,
   input  logic             reset_n,
   palette_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t      state;
   logic [3:0]  slot;
   logic [5:0]  entry;
   logic [1:0]  byte_cnt;
   logic [23:0] entry_reg;
   logic        restart_pend;
   logic [3:0]  restart_slot;
   logic        dl_err_q;

   logic        pix_d1;
   logic        pix_valid_q;
   logic [23:0] pix_data_q;

   logic        wr_issue;
   logic        restart_now;
   logic [3:0]  restart_sel;

   // Pixel lookups always win the RAM cycle; a pending write simply waits.
   assign wr_issue = (state == WRITE) && !bus.pix_req;

   // A restart requested during WRITE is held until the write has gone out.
   always_comb begin
      restart_now = 1'b0;
      restart_sel = bus.dl_slot;
      if (state == WRITE) begin
         restart_now = wr_issue && (bus.dl_start || restart_pend);
         if (!bus.dl_start)
            restart_sel = restart_slot;
      end else begin
         restart_now = bus.dl_start;
      end
   end

`ifdef PALETTE_READBACK_EN
   logic        rb_pend;
   logic        rb_d1;
   logic        rb_valid_q;
   logic [23:0] rb_data_q;
   logic        rb_serve;

   // rb_pend keeps a held rb_req from being served a second time.
   assign rb_serve = bus.rb_req && !bus.pix_req && !wr_issue && !rb_pend;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rb_pend    <= 1'b0;
         rb_d1      <= 1'b0;
         rb_valid_q <= 1'b0;
         rb_data_q  <= '0;
      end else begin
         rb_d1      <= rb_serve;
         rb_valid_q <= rb_d1;
         if (rb_d1)
            rb_data_q <= bus.mem_rdata;
         if (rb_serve)
            rb_pend <= 1'b1;
         else if (rb_valid_q)
            rb_pend <= 1'b0;
      end
   end

   assign bus.rb_valid = rb_valid_q;
   assign bus.rb_data  = rb_data_q;
`endif

   // RAM port is combinational so the pixel address reaches the RAM in the
   // request cycle; reset_n gates it to zero asynchronously.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      if (reset_n) begin
         if (bus.pix_req) begin
            bus.mem_addr = bus.pix_addr;
         end else if (wr_issue) begin
            bus.mem_addr  = {slot, entry};
            bus.mem_we    = 1'b1;
            bus.mem_wdata = entry_reg;
         end
`ifdef PALETTE_READBACK_EN
         else if (rb_serve) begin
            bus.mem_addr = bus.rb_addr;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         slot         <= '0;
         entry        <= '0;
         byte_cnt     <= '0;
         entry_reg    <= '0;
         restart_pend <= 1'b0;
         restart_slot <= '0;
         dl_err_q     <= 1'b0;
      end else begin
         dl_err_q <= 1'b0;
         if (restart_now) begin
            restart_pend <= 1'b0;
            byte_cnt     <= '0;
            entry        <= '0;
            entry_reg    <= '0;
            if (restart_sel != 4'hF) begin
               slot  <= restart_sel;
               state <= COLLECT;
            end else begin
               dl_err_q <= 1'b1;
               state    <= IDLE;
            end
         end else begin
            case (state)
               IDLE: ;
               COLLECT: begin
                  if (bus.dl_valid) begin
                     case (byte_cnt)
                        2'd0: begin
                           entry_reg[23:16] <= bus.dl_byte;
                           byte_cnt         <= 2'd1;
                        end
                        2'd1: begin
                           entry_reg[15:8] <= bus.dl_byte;
                           byte_cnt        <= 2'd2;
                        end
                        default: begin
                           entry_reg[7:0] <= bus.dl_byte;
                           byte_cnt       <= 2'd0;
                           state          <= WRITE;
                        end
                     endcase
                  end
               end
               WRITE: begin
                  if (wr_issue) begin
                     if (entry == 6'd63) begin
                        state <= DONE;
                     end else begin
                        entry <= entry + 6'd1;
                        state <= COLLECT;
                     end
                  end else if (bus.dl_start) begin
                     restart_pend <= 1'b1;
                     restart_slot <= bus.dl_slot;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Fixed two-cycle pixel pipeline: address in N, RAM data in N+1, output in N+2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_d1      <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
      end else begin
         pix_d1      <= bus.pix_req;
         pix_valid_q <= pix_d1;
         if (pix_d1)
            pix_data_q <= bus.mem_rdata;
      end
   end

   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_data  = pix_data_q;
   assign bus.dl_ready  = (state == COLLECT);
   assign bus.dl_done   = (state == DONE);
   assign bus.dl_err    = dl_err_q;
endmodule

// File: tb/tb_palette_arbiter.sv
module tb_palette_arbiter;
   localparam logic [23:0] SENT = 24'h5A5A5A;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   palette_arbiter_if bus ();

   palette_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   logic [23:0] ram [1024] = '{default: 24'h5A5A5A};
   always @(posedge clk) begin
      if (bus.mem_we)
         ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int n_chk = 0, n_pass = 0;
   int timeouts = 0;
   int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
   int coll_cnt = 0, addr_err = 0, pix_err = 0, pix_cnt = 0;
   logic pix_en = 1'b0;
   logic h1_req = 1'b0, h2_req = 1'b0;
   logic [23:0] h1_data = '0, h2_data = '0;

   always @(negedge clk) begin
      if (bus.mem_we) wr_cnt++;
      if (bus.dl_done) done_cnt++;
      if (bus.dl_err) err_cnt++;
      if (bus.pix_req && bus.mem_we) coll_cnt++;
      if (bus.pix_req && bus.mem_addr !== bus.pix_addr) addr_err++;
      if (bus.pix_valid !== h2_req) pix_err++;
      if (h2_req) begin
         pix_cnt++;
         if (bus.pix_data !== h2_data) pix_err++;
      end
      h2_req  = h1_req;
      h2_data = h1_data;
      h1_req  = bus.pix_req;
      h1_data = ram[bus.pix_addr];
   end

   // Pixel requests every second cycle while enabled.
   initial begin
      bus.pix_req  = 1'b0;
      bus.pix_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         if (pix_en && !bus.pix_req) begin
            bus.pix_req  = 1'b1;
            bus.pix_addr = 10'($urandom_range(0, 1023));
         end else begin
            bus.pix_req = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_dl(input logic [3:0] s);
      bus.dl_start = 1'b1;
      bus.dl_slot  = s;
      step(1);
      bus.dl_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      logic ok;
      n = 0;
      ok = 1'b0;
      bus.dl_valid = 1'b1;
      bus.dl_byte  = b;
      while (!ok && n < 20) begin
         @(negedge clk);
         ok = bus.dl_ready;
         step(1);
         n++;
      end
      bus.dl_valid = 1'b0;
      if (!ok) timeouts++;
   endtask

   task automatic send_bytes(input int base, input int cnt);
      for (int i = 0; i < cnt; i++)
         send_byte(8'(base + i));
   endtask

   task automatic wait_done(input int exp);
      int n;
      n = 0;
      while (done_cnt < exp && n < 30) begin
         step(1);
         n++;
      end
      if (done_cnt < exp) timeouts++;
   endtask

   function automatic int bad_entries(input int s, input int base, input int n);
      int bad;
      logic [23:0] exp;
      bad = 0;
      for (int e = 0; e < n; e++) begin
         exp = {8'(base + 3 * e), 8'(base + 3 * e + 1), 8'(base + 3 * e + 2)};
         if (ram[s * 64 + e] !== exp) bad++;
      end
      return bad;
   endfunction

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
      chk({tag, "_pix_data"},  32'(bus.pix_data),  0);
      chk({tag, "_dl_ready"},  32'(bus.dl_ready),  0);
      chk({tag, "_dl_done"},   32'(bus.dl_done),   0);
      chk({tag, "_dl_err"},    32'(bus.dl_err),    0);
      chk({tag, "_mem_we"},    32'(bus.mem_we),    0);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
   endtask

   int wr0, dn0, er0;

   initial begin
      bus.dl_start = 1'b0;
      bus.dl_slot  = '0;
      bus.dl_valid = 1'b0;
      bus.dl_byte  = '0;
`ifdef PALETTE_READBACK_EN
      bus.rb_req  = 1'b0;
      bus.rb_addr = '0;
`endif
      #12;
      chk_outputs_zero("reset");
      step(2);
      reset_n = 1'b1;
      step(2);

      // Slot 3, bytes 0x00..0xBF, no pixel traffic
      wr0 = wr_cnt; dn0 = done_cnt;
      start_dl(4'd3);
      send_bytes(0, 192);
      wait_done(dn0 + 1);
      step(3);
      chk("s3_writes", 32'(wr_cnt - wr0), 64);
      chk("s3_done", 32'(done_cnt - dn0), 1);
      chk("s3_entry0", 32'(ram[10'h0C0]), 32'h000102);
      chk("s3_entry63", 32'(ram[10'h0FF]), 32'hBDBEBF);
      chk("s3_bad", 32'(bad_entries(3, 0, 64)), 0);
      chk("s2_untouched", 32'(ram[10'h0BF]), 32'(SENT));
      chk("s4_untouched", 32'(ram[10'h100]), 32'(SENT));

`ifdef PALETTE_READBACK_EN
      begin
         int n;
         logic got;
         logic [23:0] rbd;
         n = 0;
         got = 1'b0;
         rbd = '0;
         bus.rb_req  = 1'b1;
         bus.rb_addr = 10'h0C0;
         while (!got && n < 10) begin
            @(negedge clk);
            got = bus.rb_valid;
            rbd = bus.rb_data;
            step(1);
            n++;
         end
         bus.rb_req = 1'b0;
         chk("rb_valid", 32'(got), 1);
         chk("rb_data", 32'(rbd), 32'h000102);
         chk("rb_latency", 32'(n), 3);
      end
`endif

      // Slot 0 download with pixel requests every second cycle
      wr0 = wr_cnt; dn0 = done_cnt;
      pix_en = 1'b1;
      start_dl(4'd0);
      send_bytes(8'h40, 192);
      wait_done(dn0 + 1);
      pix_en = 1'b0;
      step(4);
      chk("pix_collisions", 32'(coll_cnt), 0);
      chk("pix_addr_err", 32'(addr_err), 0);
      chk("pix_lat_err", 32'(pix_err), 0);
      chk("pix_seen", 32'(pix_cnt > 100), 1);
      chk("s0_writes", 32'(wr_cnt - wr0), 64);
      chk("s0_bad", 32'(bad_entries(0, 8'h40, 64)), 0);
      chk("s0_done", 32'(done_cnt - dn0), 1);

      // Slot 15 is rejected
      wr0 = wr_cnt; er0 = err_cnt;
      start_dl(4'hF);
      @(negedge clk);
      chk("err_pulse", 32'(bus.dl_err), 1);
      step(1);
      @(negedge clk);
      chk("err_one_cycle", 32'(bus.dl_err), 0);
      chk("err_idle", 32'(bus.dl_ready), 0);
      step(3);
      chk("err_count", 32'(err_cnt - er0), 1);
      chk("err_no_write", 32'(wr_cnt - wr0), 0);

      // Abort after 100 bytes to slot 6, then full download to slot 5
      wr0 = wr_cnt; dn0 = done_cnt;
      start_dl(4'd6);
      send_bytes(8'h10, 100);
      start_dl(4'd5);
      send_bytes(8'h80, 192);
      wait_done(dn0 + 1);
      step(3);
      chk("abort_partial", 32'(ram[6 * 64 + 33]), 32'(SENT));
      chk("abort_prefix", 32'(bad_entries(6, 8'h10, 33)), 0);
      chk("s5_bad", 32'(bad_entries(5, 8'h80, 64)), 0);
      chk("abort_done", 32'(done_cnt - dn0), 1);
      chk("abort_writes", 32'(wr_cnt - wr0), 97);

      // Reset after 50 bytes to slot 7
      start_dl(4'd7);
      send_bytes(8'h20, 50);
      reset_n = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      step(2);
      reset_n = 1'b1;
      step(2);
      @(negedge clk);
      chk("rst_idle", 32'(bus.dl_ready), 0);
      chk("rst_kept", 32'(bad_entries(7, 8'h20, 16)), 0);
      chk("rst_entry16", 32'(ram[7 * 64 + 16]), 32'(SENT));
      chk("timeouts", 32'(timeouts), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
